// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - condition codes, flag register type and reset value for cond_unit
package cond_pkg;

  typedef enum logic [3:0] {
    COND_NEVER = 4'd0,
    COND_EQ    = 4'd1,
    COND_LT    = 4'd2,
    COND_LE    = 4'd3,
    COND_AL    = 4'd4,
    COND_NE    = 4'd5,
    COND_GE    = 4'd6,
    COND_GT    = 4'd7,
    COND_LTU   = 4'd8,
    COND_LEU   = 4'd9,
    COND_GEU   = 4'd10,
    COND_GTU   = 4'd11,
    COND_MI    = 4'd12,
    COND_VS    = 4'd13,
    COND_RSV14 = 4'd14,
    COND_RSV15 = 4'd15
  } cond_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

  localparam flags_t FLAGS_RESET = '{z: 1'b1, n: 1'b0, c: 1'b0, v: 1'b0};

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational condition decode from flags and condition code
module cond_eval
  import cond_pkg::*;
(
  input  flags_t flags,
  input  cond_e  cond,
  output logic   taken,
  output logic   illegal
);

  logic lt_s;
  logic le_u;

  assign lt_s = flags.n ^ flags.v;
  assign le_u = !flags.c | flags.z;

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (cond)
      COND_NEVER: taken = 1'b0;
      COND_EQ:    taken = flags.z;
      COND_LT:    taken = lt_s;
      COND_LE:    taken = flags.z | lt_s;
      COND_AL:    taken = 1'b1;
      COND_NE:    taken = !flags.z;
      COND_GE:    taken = !lt_s;
      COND_GT:    taken = !flags.z & !lt_s;
      COND_LTU:   taken = !flags.c;
      COND_LEU:   taken = le_u;
      COND_GEU:   taken = flags.c;
      COND_GTU:   taken = !le_u;
      COND_MI:    taken = flags.n;
      COND_VS:    taken = flags.v;
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - flag register, single-stage condition request/result pipe and taken counter
module cond_unit
  import cond_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flags_we,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_ovf,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_cond,
  input  logic              req_src,
  input  logic [DATA_W-1:0] req_value,
  output logic              res_valid,
  output logic              res_taken,
  output logic              res_illegal,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  taken_count
);

  flags_t flags_q;
  flags_t alu_flags;
  flags_t val_flags;
  flags_t eval_flags;
  logic   eval_taken;
  logic   eval_illegal;
  logic   accept;
  logic   drain;

  assign alu_flags = '{z: ~|alu_result, n: alu_result[DATA_W-1], c: alu_carry, v: alu_ovf};
  assign val_flags = '{z: ~|req_value, n: req_value[DATA_W-1], c: 1'b0, v: 1'b0};

  // Flags written this cycle are visible to a same-cycle register-sourced request.
  assign eval_flags = req_src  ? val_flags :
                      flags_we ? alu_flags : flags_q;

  assign req_ready = !res_valid | res_ready;
  assign accept    = req_valid & req_ready;
  assign drain     = res_valid & res_ready;

  cond_eval u_eval (
    .flags   (eval_flags),
    .cond    (cond_e'(req_cond)),
    .taken   (eval_taken),
    .illegal (eval_illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q     <= FLAGS_RESET;
      res_valid   <= 1'b0;
      res_taken   <= 1'b0;
      res_illegal <= 1'b0;
      taken_count <= '0;
    end else begin
      if (flags_we) begin
        flags_q <= alu_flags;
      end
      if (accept) begin
        res_valid   <= 1'b1;
        res_taken   <= eval_taken;
        res_illegal <= eval_illegal;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
      if (drain && res_taken && (taken_count != {CNT_W{1'b1}})) begin
        taken_count <= taken_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cond_unit.sv
// tb/tb_cond_unit.sv - randomized and directed check of cond_unit against a behavioural model
module tb_cond_unit;

  logic        clk;
  logic        reset;
  logic        flags_we;
  logic [7:0]  alu_result;
  logic        alu_carry;
  logic        alu_ovf;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_cond;
  logic        req_src;
  logic [7:0]  req_value;
  logic        res_valid;
  logic        res_taken;
  logic        res_illegal;
  logic        res_ready;
  logic [15:0] taken_count;

  logic        req_ready2;
  logic        res_valid2;
  logic        res_taken2;
  logic        res_illegal2;
  logic [1:0]  taken_count2;

  int tests;
  int fails;
  bit run;

  // model state
  bit m_z, m_n, m_c, m_v;
  bit m_valid, m_taken, m_illegal;
  int m_cnt, m_cnt2;

  cond_unit #(.DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flags_we(flags_we), .alu_result(alu_result),
    .alu_carry(alu_carry), .alu_ovf(alu_ovf), .req_valid(req_valid),
    .req_ready(req_ready), .req_cond(req_cond), .req_src(req_src),
    .req_value(req_value), .res_valid(res_valid), .res_taken(res_taken),
    .res_illegal(res_illegal), .res_ready(res_ready), .taken_count(taken_count)
  );

  cond_unit #(.DATA_W(8), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .flags_we(flags_we), .alu_result(alu_result),
    .alu_carry(alu_carry), .alu_ovf(alu_ovf), .req_valid(req_valid),
    .req_ready(req_ready2), .req_cond(req_cond), .req_src(req_src),
    .req_value(req_value), .res_valid(res_valid2), .res_taken(res_taken2),
    .res_illegal(res_illegal2), .res_ready(res_ready), .taken_count(taken_count2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Returns {illegal, taken} from the condition table using signed/unsigned meaning.
  function automatic logic [1:0] ref_cond(input int code, input bit z, input bit n, input bit c, input bit v);
    bit lt_s;
    bit lt_u;
    lt_s = (n != v);
    lt_u = !c;
    case (code)
      0:  return 2'b00;
      1:  return {1'b0, z};
      2:  return {1'b0, lt_s};
      3:  return {1'b0, lt_s || z};
      4:  return 2'b01;
      5:  return {1'b0, !z};
      6:  return {1'b0, !lt_s};
      7:  return {1'b0, !lt_s && !z};
      8:  return {1'b0, lt_u};
      9:  return {1'b0, lt_u || z};
      10: return {1'b0, !lt_u};
      11: return {1'b0, !lt_u && !z};
      12: return {1'b0, n};
      13: return {1'b0, v};
      default: return 2'b10;
    endcase
  endfunction

  task automatic model_reset();
    {m_z, m_n, m_c, m_v} = 4'b1000;
    m_valid = 0; m_taken = 0; m_illegal = 0;
    m_cnt = 0; m_cnt2 = 0;
  endtask

  task automatic model_clock();
    bit accept;
    bit ez, en, ec, ev;
    logic [1:0] r;
    accept = req_valid && (!m_valid || res_ready);
    if (req_src) begin
      ez = (req_value == 0); en = req_value[7]; ec = 0; ev = 0;
    end else if (flags_we) begin
      ez = (alu_result == 0); en = alu_result[7]; ec = alu_carry; ev = alu_ovf;
    end else begin
      ez = m_z; en = m_n; ec = m_c; ev = m_v;
    end
    if (m_valid && res_ready && m_taken) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    if (flags_we) begin
      m_z = (alu_result == 0); m_n = alu_result[7]; m_c = alu_carry; m_v = alu_ovf;
    end
    if (accept) begin
      r = ref_cond(int'(req_cond), ez, en, ec, ev);
      m_valid = 1; m_illegal = r[1]; m_taken = r[0];
    end else if (res_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic step(input logic we, input logic [7:0] alu, input logic cy, input logic ov,
                      input logic v, input logic [3:0] cond, input logic src, input logic [7:0] val,
                      input logic rr, input logic rst);
    flags_we = we; alu_result = alu; alu_carry = cy; alu_ovf = ov;
    req_valid = v; req_cond = cond; req_src = src; req_value = val;
    res_ready = rr; reset = rst;
    if (rst) model_reset();
    @(posedge clk);
    if (!rst) model_clock();
    #2;
  endtask

  task automatic req(input logic [3:0] cond, input logic src, input logic [7:0] val, input logic rr);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, cond, src, val, rr, 1'b0);
  endtask

  task automatic idle(input logic rr);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00, rr, 1'b0);
  endtask

  // Compare process: DUT against model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (run) begin
      chk("res_valid", res_valid, m_valid);
      chk("req_ready", req_ready, !m_valid || res_ready);
      if (m_valid || reset) begin
        chk("res_taken", res_taken, m_taken);
        chk("res_illegal", res_illegal, m_illegal);
      end
      chk("taken_count", taken_count, m_cnt);
      chk("taken_count_w2", taken_count2, m_cnt2);
      chk("res_valid_w2", res_valid2, m_valid);
    end
  end

  initial begin
    tests = 0; fails = 0;
    reset = 1; flags_we = 0; alu_result = 0; alu_carry = 0; alu_ovf = 0;
    req_valid = 0; req_cond = 0; req_src = 0; req_value = 0; res_ready = 0;
    model_reset();
    run = 1;

    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_req_ready", req_ready, 1);
    idle(1'b0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_count", taken_count, 0);
    chk("post_rst_req_ready", req_ready, 1);

    // value-sourced conditions on zero
    req(4'd1, 1, 8'h00, 1); chk("val0_eq", {res_valid, res_taken}, 2'b11);
    req(4'd3, 1, 8'h00, 1); chk("val0_le", {res_valid, res_taken}, 2'b11);
    req(4'd6, 1, 8'h00, 1); chk("val0_ge", {res_valid, res_taken}, 2'b11);
    req(4'd7, 1, 8'h00, 1); chk("val0_gt", {res_valid, res_taken}, 2'b10);

    // same-cycle flag write bypass
    step(1, 8'h80, 0, 1, 1, 4'd2, 0, 8'h00, 1, 0);
    chk("bypass_lt", {res_valid, res_taken}, 2'b10);
    req(4'd8, 0, 8'h00, 1); chk("flags_ltu", res_taken, 1);

    // reserved code
    req(4'd14, 0, 8'h00, 1);
    chk("rsv_flags", {res_taken, res_illegal}, 2'b01);
    chk("rsv_count_a", taken_count, 4);
    idle(1'b1);
    chk("rsv_count_b", taken_count, 4);

    // backpressure and no-bubble restart
    req(4'd4, 1, 8'h00, 0);
    for (int i = 0; i < 3; i++) begin
      req(4'd0, 1, 8'h00, 0);
      chk("stall_ready", req_ready, 0);
      chk("stall_hold", {res_valid, res_taken}, 2'b11);
    end
    req(4'd0, 1, 8'h00, 1); chk("b2b_first", {res_valid, res_taken}, 2'b10);
    req(4'd4, 1, 8'h00, 1); chk("b2b_second", {res_valid, res_taken}, 2'b11);
    chk("count_five", taken_count, 5);
    chk("count_sat_w2", taken_count2, 3);

    // asynchronous reset while a result is held
    idle(1'b0);
    reset = 1; model_reset();
    #1;
    chk("async_res_valid", res_valid, 0);
    chk("async_count", taken_count, 0);
    chk("async_count_w2", taken_count2, 0);
    chk("async_req_ready", req_ready, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    req(4'd1, 0, 8'h00, 1); chk("rst_flag_z", res_taken, 1);
    req(4'd12, 0, 8'h00, 1); chk("rst_flag_n", res_taken, 0);
    req(4'd10, 0, 8'h00, 1); chk("rst_flag_c", res_taken, 0);
    chk("rst_count_after", taken_count, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) == 0, 8'($urandom), 1'($urandom), 1'($urandom),
           ($urandom % 4) != 0, 4'($urandom), 1'($urandom),
           (($urandom % 4) == 0) ? 8'h00 : 8'($urandom),
           ($urandom % 3) != 0, ($urandom % 250) == 0);
    end

    idle(1'b1);
    run = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
